sprite_blitter: RTL and testbench

//  Draw engine downstream of the CHIP-8 cpu. Executes Dxyn (XOR an n-byte sprite from RAM at I into the

---
 rtl/sprite_blitter.sv | 174 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - CHIP-8 draw engine: Dxyn sprite XOR-blit and 00E0 clear
//
// Purpose: executes one draw or clear command at a time. Sprite bytes are read from
// RAM, framebuffer rows are read-modify-written one row word per access.
// Optional feature: define SPRITE_WRAP_EN to wrap rows/columns instead of clipping.
//
// Ports:
//   clk, rst_n              clock (posedge), asynchronous active-low reset
//   req_valid/req_ready     command handshake (ready only while idle)
//   req_clear               1 = clear screen, 0 = draw sprite
//   req_x, req_y, req_n     sprite origin and height in bytes
//   req_addr                sprite base address in RAM
//   done, collision         completion pulse and XOR collision flag
//   mem_rd/mem_addr/mem_rdata       RAM byte read, data one cycle after strobe
//   vram_re/vram_addr/vram_rdata    framebuffer row read, data one cycle after strobe
//   vram_we/vram_wdata              framebuffer row write (bit SCREEN_W-1 = x 0)
module sprite_blitter #(
  parameter  int SCREEN_W = 64,
  parameter  int SCREEN_H = 32,
  parameter  int ADDR_W   = 12,
  localparam int RW       = $clog2(SCREEN_H)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_clear,
  input  logic [7:0]          req_x,
  input  logic [7:0]          req_y,
  input  logic [3:0]          req_n,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                done,
  output logic                collision,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rdata,
  output logic                vram_re,
  output logic [RW-1:0]       vram_addr,
  input  logic [SCREEN_W-1:0] vram_rdata,
  output logic                vram_we,
  output logic [SCREEN_W-1:0] vram_wdata
);

  // Counter serves both as clear row index and sprite row index.
  localparam int CW = (RW > 4) ? RW : 4;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_READ, S_WRITE, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [7:0]          r_x, r_y;
  logic [3:0]          r_n;
  logic [ADDR_W-1:0]   r_addr;
  logic [CW-1:0]       r_cnt;
  logic [7:0]          r_byte;
  logic                r_coll;

  logic [CW-1:0]       w_cnt_inc;
  logic                w_last;
  logic [8:0]          w_row_sum;
  logic                w_clipped;
  logic [RW-1:0]       w_vrow;
  logic [SCREEN_W-1:0] w_spr;
  logic [SCREEN_W-1:0] w_mask;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (w_cnt_inc == CW'(r_n));
  // Start coordinates always wrap; only the per-row offset can run off the bottom.
  assign w_row_sum = 9'(r_y % 8'(SCREEN_H)) + 9'(r_cnt);
  assign w_vrow    = RW'(w_row_sum);
  assign w_spr     = {r_byte, {(SCREEN_W-8){1'b0}}};

`ifdef SPRITE_WRAP_EN
  logic [2*SCREEN_W-1:0] w_dbl;
  // Low half of a doubled word shifted right is a rotate right.
  assign w_dbl     = {w_spr, w_spr} >> (r_x % 8'(SCREEN_W));
  assign w_mask    = w_dbl[SCREEN_W-1:0];
  assign w_clipped = 1'b0;
`else
  assign w_mask    = w_spr >> (r_x % 8'(SCREEN_W));
  assign w_clipped = (w_row_sum >= 9'(SCREEN_H));
`endif

  assign collision = r_coll;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    done       = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    vram_re    = 1'b0;
    vram_we    = 1'b0;
    vram_addr  = '0;
    vram_wdata = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_clear)       w_next = S_CLEAR;
          else if (req_n == 0) w_next = S_DONE;
          else                 w_next = S_FETCH;
        end
      end
      S_CLEAR: begin
        vram_we   = 1'b1;
        vram_addr = RW'(r_cnt);
        if (r_cnt == CW'(SCREEN_H-1)) w_next = S_DONE;
      end
      S_FETCH: begin
        if (w_clipped) begin
          // Off-screen row: burn one cycle with no strobes.
          if (w_last) w_next = S_DONE;
        end else begin
          mem_rd   = 1'b1;
          mem_addr = r_addr + ADDR_W'(r_cnt);
          w_next   = S_READ;
        end
      end
      S_READ: begin
        vram_re   = 1'b1;
        vram_addr = w_vrow;
        w_next    = S_WRITE;
      end
      S_WRITE: begin
        vram_we    = 1'b1;
        vram_addr  = w_vrow;
        vram_wdata = vram_rdata ^ w_mask;
        w_next     = w_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_n    <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
      r_byte <= '0;
      r_coll <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_x    <= req_x;
          r_y    <= req_y;
          r_n    <= req_n;
          r_addr <= req_addr;
          r_cnt  <= '0;
          r_coll <= 1'b0;
        end
        S_CLEAR: r_cnt <= w_cnt_inc;
        S_FETCH: if (w_clipped) r_cnt <= w_cnt_inc;
        S_READ:  r_byte <= mem_rdata;
        S_WRITE: begin
          r_coll <= r_coll | (|(vram_rdata & w_mask));
          r_cnt  <= w_cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - self-checking bench for sprite_blitter (vectors + random vs pixel model)
module tb_sprite_blitter;

  localparam int W = 64;
  localparam int H = 32;
`ifdef SPRITE_WRAP_EN
  localparam bit WRAP = 1'b1;
  localparam int L4 = 7;
  localparam int M4 = 2;
  localparam logic [63:0] R31 = 64'hF000_0000_0000_000F;
  localparam logic [63:0] R0  = 64'hF000_0000_0000_000F;
`else
  localparam bit WRAP = 1'b0;
  localparam int L4 = 5;
  localparam int M4 = 1;
  localparam logic [63:0] R31 = 64'h0000_0000_0000_000F;
  localparam logic [63:0] R0  = 64'h0;
`endif

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0, req_ready, req_clear = 0;
  logic [7:0]  req_x = 0, req_y = 0;
  logic [3:0]  req_n = 0;
  logic [11:0] req_addr = 0;
  logic        done, collision, mem_rd, vram_re, vram_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = 0;
  logic [4:0]  vram_addr;
  logic [63:0] vram_rdata = 0, vram_wdata;

  logic [7:0]  ram [4096];
  logic [63:0] vram [H];
  logic [63:0] fb_m [H];

  int n_checks = 0;
  int n_errors = 0;

  sprite_blitter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_clear(req_clear), .req_x(req_x), .req_y(req_y), .req_n(req_n),
    .req_addr(req_addr), .done(done), .collision(collision), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .vram_re(vram_re),
    .vram_addr(vram_addr), .vram_rdata(vram_rdata), .vram_we(vram_we),
    .vram_wdata(vram_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd)  mem_rdata  <= ram[mem_addr];
    if (vram_re) vram_rdata <= vram[vram_addr];
    if (vram_we) vram[vram_addr] <= vram_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pixel-level reference: walks sprite bits and screen coordinates directly.
  task automatic model_cmd(input bit clr, input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] n, input logic [11:0] a,
                           output int lat, output bit coll);
    coll = 0;
    if (clr) begin
      for (int i = 0; i < H; i++) fb_m[i] = '0;
      lat = H + 1;
    end else begin
      lat = 1;
      for (int r = 0; r < int'(n); r++) begin
        int row;
        logic [7:0] b;
        row = (int'(y) % H) + r;
        b = ram[(int'(a) + r) % 4096];
        if (row >= H) begin
          if (WRAP) row -= H;
          else begin lat += 1; continue; end
        end
        lat += 3;
        for (int k = 0; k < 8; k++) begin
          int px;
          px = (int'(x) % W) + k;
          if (px >= W) begin
            if (WRAP) px -= W;
            else continue;
          end
          if (b[7-k]) begin
            if (fb_m[row][63-px]) coll = 1;
            fb_m[row][63-px] = ~fb_m[row][63-px];
          end
        end
      end
    end
  endtask

  task automatic run_cmd(input bit clr, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] a,
                         output int lat, output bit coll, output int mrd,
                         output bit bad, output bit got);
    @(negedge clk);
    chk("ready_before_cmd", req_ready, 1);
    req_valid = 1; req_clear = clr; req_x = x; req_y = y; req_n = n; req_addr = a;
    lat = 0; coll = 0; mrd = 0; bad = 0; got = 0;
    @(posedge clk);
    #1;
    req_valid = 0;
    req_clear = $urandom; req_x = $urandom; req_y = $urandom;
    req_n = $urandom; req_addr = $urandom;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (mem_rd) mrd++;
      if (int'(mem_rd) + int'(vram_re) + int'(vram_we) > 1) bad = 1;
      if (done) begin got = 1; coll = collision; end
    end
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("done_one_cycle", {done, req_ready}, 2'b01);
  endtask

  typedef struct {
    bit clr; logic [7:0] x; logic [7:0] y; logic [3:0] n; logic [11:0] addr;
    int lat; bit coll; int mrd;
    int ra; logic [63:0] va; int rb; logic [63:0] vb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, mrd, elat, mism;
    bit coll, bad, got, ecoll, strobe_seen;

    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < H; i++) begin vram[i] = '0; fb_m[i] = '0; end
    ram[12'h050] = 8'hF0;
    ram[12'h100] = 8'hFF;
    ram[12'h101] = 8'hFF;
    ram[12'h200] = 8'hB5;

    vecs[0] = '{1'b1, 8'd0,  8'd0,  4'd0, 12'h000, H+1, 1'b0, 0,  0, 64'h0, 31, 64'h0};
    vecs[1] = '{1'b0, 8'd0,  8'd0,  4'd1, 12'h050, 4,   1'b0, 1,  0, 64'hF000_0000_0000_0000, 1, 64'h0};
    vecs[2] = '{1'b0, 8'd0,  8'd0,  4'd1, 12'h050, 4,   1'b1, 1,  0, 64'h0, 1, 64'h0};
    vecs[3] = '{1'b0, 8'd60, 8'd31, 4'd2, 12'h100, L4,  1'b0, M4, 31, R31, 0, R0};
    vecs[4] = '{1'b0, 8'd70, 8'd40, 4'd0, 12'h200, 1,   1'b0, 0,  8, 64'h0, 31, R31};
    vecs[5] = '{1'b0, 8'd70, 8'd40, 4'd1, 12'h200, 4,   1'b0, 1,  8, 64'h02D4_0000_0000_0000, 0, R0};

    // Reset state
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_outs", {done, collision, mem_rd, vram_re, vram_we}, 5'b0);
    chk("rst_addr", {mem_addr, vram_addr, vram_wdata}, '0);
    @(negedge clk);
    rst_n = 1;

    // Directed vectors
    foreach (vecs[i]) begin
      model_cmd(vecs[i].clr, vecs[i].x, vecs[i].y, vecs[i].n, vecs[i].addr, elat, ecoll);
      run_cmd(vecs[i].clr, vecs[i].x, vecs[i].y, vecs[i].n, vecs[i].addr, lat, coll, mrd, bad, got);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_collision", i), coll, vecs[i].coll);
      chk($sformatf("vec%0d_mem_rd", i), mrd, vecs[i].mrd);
      chk($sformatf("vec%0d_one_strobe", i), bad, 0);
      chk($sformatf("vec%0d_row%0d", i, vecs[i].ra), vram[vecs[i].ra], vecs[i].va);
      chk($sformatf("vec%0d_row%0d", i, vecs[i].rb), vram[vecs[i].rb], vecs[i].vb);
    end

    // Randomized commands against the pixel model
    for (int t = 0; t < 40; t++) begin
      bit c;
      logic [7:0] x, y;
      logic [3:0] n;
      logic [11:0] a;
      c = ($urandom_range(0, 9) == 0);
      x = 8'($urandom); y = 8'($urandom); n = 4'($urandom); a = 12'($urandom);
      model_cmd(c, x, y, n, a, elat, ecoll);
      run_cmd(c, x, y, n, a, lat, coll, mrd, bad, got);
      chk($sformatf("rnd%0d_latency", t), lat, elat);
      chk($sformatf("rnd%0d_collision", t), coll, ecoll);
      chk($sformatf("rnd%0d_one_strobe", t), bad, 0);
      mism = 0;
      for (int i = 0; i < H; i++) if (vram[i] !== fb_m[i]) mism++;
      chk($sformatf("rnd%0d_fb_rows_wrong", t), mism, 0);
    end

    // Reset in the middle of a long draw
    @(negedge clk);
    req_valid = 1; req_clear = 0; req_x = 0; req_y = 0; req_n = 15; req_addr = 12'h000;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_ready", req_ready, 1);
    chk("midrst_outs", {done, collision, mem_rd, vram_re, vram_we}, 5'b0);
    strobe_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done | mem_rd | vram_re | vram_we) strobe_seen = 1;
    end
    chk("midrst_quiet", strobe_seen, 0);
    rst_n = 1;
    model_cmd(1'b1, 8'd0, 8'd0, 4'd0, 12'h0, elat, ecoll);
    run_cmd(1'b1, 8'd0, 8'd0, 4'd0, 12'h0, lat, coll, mrd, bad, got);
    chk("post_rst_clear_latency", lat, H + 1);
    mism = 0;
    for (int i = 0; i < H; i++) if (vram[i] !== 64'h0) mism++;
    chk("post_rst_clear_rows_nonzero", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
